mips_mem_loader: RTL

- Hardware counterpart to the bench's memory preload and result dump: loads InstrMem and DataMem of PipelinedMIPS from a byte stream, then releases the processor from reset.
- Sits between a byte source (UART receiver or host FIFO) and the processor's memory write ports.
- Owns the processor reset line `cpu_rstb`, which is held low until a GO frame arrives.

---
 rtl/mips_loader_pkg.sv | 23 ++
 rtl/loader_word_assembler.sv | 55 +++++
 rtl/mips_mem_loader.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mips_loader_pkg.sv
// Shared types and constants for the MIPS memory loader.
package mips_loader_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 10;
  localparam logic [7:0]  SYNC_DEFAULT   = 8'hA5;

  localparam logic [7:0] TGT_INSTR = 8'h00;
  localparam logic [7:0] TGT_DATA  = 8'h01;
  localparam logic [7:0] TGT_GO    = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TGT,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_RUN
  } ld_state_e;

endpackage

// File: rtl/loader_word_assembler.sv
// Byte-to-word shifter, byte counter and running XOR checksum for one frame.
module loader_word_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_en,
  input  logic        csum_en,
  input  logic [7:0]  in_data,
  output logic [31:0] word_c,
  output logic        word_done_c,
  output logic [7:0]  csum_q
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  csum_d;

  // The completed word includes the byte being accepted this cycle.
  assign word_c      = {shift_q, in_data};
  assign word_done_c = byte_en && (cnt_q == 2'd3);

  // Next-state for shifter, counter and checksum.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
      csum_d  = '0;
    end else begin
      if (byte_en) begin
        shift_d = {shift_q[15:0], in_data};
        cnt_d   = cnt_q + 2'd1;
      end
      if (csum_en) begin
        csum_d = csum_q ^ in_data;
      end
    end
  end

  // Registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
    end
  end

endmodule

// File: rtl/mips_mem_loader.sv
// Frame-based loader for InstrMem/DataMem that releases the CPU reset on GO.
module mips_mem_loader
  import mips_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter logic [7:0]  SYNC   = SYNC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rstb,
  output logic              busy,
  output logic              err_csum,
  output logic              err_tgt
);

  ld_state_e         state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic              imem_we_q, imem_we_d;
  logic              dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              cpu_rstb_q, cpu_rstb_d;
  logic              busy_q, busy_d;
  logic              err_csum_q, err_csum_d;
  logic              err_tgt_q, err_tgt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_byte_q, hi_byte_d;
  logic              tgt_data_q, tgt_data_d;

  logic        accept;
  logic        asm_clr, asm_byte_en, asm_csum_en;
  logic [31:0] asm_word;
  logic        asm_word_done;
  logic [7:0]  asm_csum;

  assign accept = in_valid && in_ready_q;

  loader_word_assembler u_asm (
    .clk         (clk),
    .rst         (rst),
    .clr         (asm_clr),
    .byte_en     (asm_byte_en),
    .csum_en     (asm_csum_en),
    .in_data     (in_data),
    .word_c      (asm_word),
    .word_done_c (asm_word_done),
    .csum_q      (asm_csum)
  );

  // Frame parser: next state, write strobes and flag updates on accepted bytes.
  always_comb begin
    state_d     = state_q;
    imem_we_d   = 1'b0;
    dmem_we_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_csum_d  = err_csum_q;
    err_tgt_d   = err_tgt_q;
    addr_d      = addr_q;
    len_d       = len_q;
    hi_byte_d   = hi_byte_q;
    tgt_data_d  = tgt_data_q;
    asm_clr     = 1'b0;
    asm_byte_en = 1'b0;
    asm_csum_en = 1'b0;

    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (in_data == SYNC) begin
            state_d = ST_TGT;
            asm_clr = 1'b1;
          end
        end
        ST_TGT: begin
          if (in_data == TGT_GO) begin
            state_d = ST_RUN;
          end else if (in_data == TGT_INSTR || in_data == TGT_DATA) begin
            tgt_data_d = (in_data == TGT_DATA);
            state_d    = ST_ADDR_HI;
          end else begin
            err_tgt_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
        ST_ADDR_HI: begin
          hi_byte_d   = in_data;
          asm_csum_en = 1'b1;
          state_d     = ST_ADDR_LO;
        end
        ST_ADDR_LO: begin
          addr_d      = ADDR_W'({hi_byte_q, in_data});
          asm_csum_en = 1'b1;
          state_d     = ST_LEN_HI;
        end
        ST_LEN_HI: begin
          hi_byte_d   = in_data;
          asm_csum_en = 1'b1;
          state_d     = ST_LEN_LO;
        end
        ST_LEN_LO: begin
          len_d       = {hi_byte_q, in_data};
          asm_csum_en = 1'b1;
          state_d     = ({hi_byte_q, in_data} == 16'd0) ? ST_CSUM : ST_DATA;
        end
        ST_DATA: begin
          asm_byte_en = 1'b1;
          asm_csum_en = 1'b1;
          if (asm_word_done) begin
            mem_wdata_d = asm_word;
            mem_addr_d  = addr_q;
            imem_we_d   = !tgt_data_q;
            dmem_we_d   = tgt_data_q;
            addr_d      = addr_q + ADDR_W'(1);
            len_d       = len_q - 16'd1;
            if (len_q == 16'd1) begin
              state_d = ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (in_data != asm_csum) begin
            err_csum_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = state_q;
      endcase
    end

    in_ready_d = (state_d != ST_RUN);
    cpu_rstb_d = (state_d == ST_RUN);
    busy_d     = (state_d != ST_IDLE) && (state_d != ST_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      imem_we_q   <= 1'b0;
      dmem_we_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rstb_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_csum_q  <= 1'b0;
      err_tgt_q   <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      hi_byte_q   <= '0;
      tgt_data_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      imem_we_q   <= imem_we_d;
      dmem_we_q   <= dmem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rstb_q  <= cpu_rstb_d;
      busy_q      <= busy_d;
      err_csum_q  <= err_csum_d;
      err_tgt_q   <= err_tgt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      hi_byte_q   <= hi_byte_d;
      tgt_data_q  <= tgt_data_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign imem_we   = imem_we_q;
  assign dmem_we   = dmem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rstb  = cpu_rstb_q;
  assign busy      = busy_q;
  assign err_csum  = err_csum_q;
  assign err_tgt   = err_tgt_q;

endmodule
